zymason_seg_loader: RTL and testbench
=====================================

Name: zymason_seg_loader

Overview:
- Host-side initiator for the 7-segment digit store's RW/sel/pin_in write protocol.
- Takes a frame of NUM_DIGITS 7-bit segment patterns and replays it as the exact cycle sequence the display FSM and digit stores accept:
  - one reset pulse,
  - then low nibble / high bits / advance for each digit,
  - then a return to scan mode.
- Between frames it drives the scan-speed code onto {pin_out, sel} so the display keeps cycling.
- Sits on the same clock as the display core and drives its RW, sel, pin_in and reset inputs directly.

Parameters:
NUM_DIGITS, 4, digits per frame; must match the display's digit count (>=2)

Ports:
clock  in  1  shared clock with the display core
reset  in  1  synchronous, active-high reset
start  in  1  request to load digits; sampled only in IDLE
digits  in  7*NUM_DIGITS  frame; digit i = digits[7i+6:7i], bit6..0 = segments g..a
scan_spd  in  5  idle scan-speed code, driven as {pin_out, sel} = scan_spd
busy  out  1  high from the cycle after start is accepted through the EXIT cycle
done  out  1  one-cycle pulse in the cycle after EXIT
tgt_reset  out  1  reset to the display core
rw  out  1  drives display RW
sel  out  1  drives display sel
pin_out  out  4  drives display pin_in

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, tgt_reset=0, rw=0, {pin_out,sel}=5'b0.
- States: IDLE, RST, LO, HI, ADV, EXIT, with a digit index idx (clog2 NUM_DIGITS bits).
- IDLE:
  - rw=0, tgt_reset=0, {pin_out,sel}=scan_spd, tracking scan_spd every cycle.
  - start=1 latches digits into frame register F, sets idx=0, goes to RST.
- RST (1 cycle): tgt_reset=1, rw=0, sel=0, pin_out=0. Next state LO.
- LO: rw=1, sel=0, pin_out=F[idx][3:0]. Next state HI.
- HI: rw=1, sel=1, pin_out={1'b0, F[idx][6:4]}.
  - Next state ADV if idx<NUM_DIGITS-1.
  - Otherwise next state EXIT.
- ADV: rw=1, sel=0, pin_out=F[idx][3:0].
  - This is the display's pointer-shift cycle. The current digit's low nibble is rewritten with its own value, so it is unchanged.
  - idx increments. Next state LO.
- EXIT: rw=0, {pin_out,sel}=scan_spd. Display returns to SCAN. Next state IDLE.
  - done=1 in the cycle after EXIT (first IDLE cycle).
- Frame length:
  - From the start-accept edge to the EXIT cycle: 3*NUM_DIGITS+1 cycles. This is 13 for NUM_DIGITS=4.
  - busy is high for exactly those cycles.
- Back-to-back frames: start is asserted in the done cycle (IDLE) is accepted. The next RST follows immediately, with no gap cycle beyond IDLE.
- start while busy: ignored and not queued. F and digits are decoupled once a frame is latched; changes to digits mid-frame have no effect.
- scan_spd changes mid-frame: ignored until EXIT/IDLE.
- reset mid-frame:
  - Immediately IDLE with reset values.
  - No done pulse.
  - The display may hold a partial frame; the next frame's RST clears it.
- Bit 3 of pin_out in HI is always 0. The display ignores it, but the bench checks it.

Test Plan:
- Reset idle: reset 2 cycles, scan_spd=5'b10101 -> after release rw=0, tgt_reset=0, pin_out=4'b1010, sel=1, busy=0.
- Single frame:
  - Stimulus: digits={7'h7F,7'h06,7'h5B,7'h3F}, start 1 cycle.
  - Cycle trace:
    - RST: tgt_reset=1.
    - Digit 0 (7'h3F): LO pin=F, HI pin=3/sel=1, ADV pin=F.
    - Digit 1 (7'h5B): LO B, HI 5, ADV B.
    - Digit 2 (7'h06): LO 6, HI 0, ADV 6.
    - Digit 3 (7'h7F): LO F, HI 7, then EXIT rw=0.
  - Timing: busy high 13 cycles; done pulses once.
  - With the display model attached, all 4 stored digits equal their inputs.
- Ignored start: start re-asserted during HI of digit1 with different digits -> trace identical to the single-frame case, single done.
- Back-to-back: start held high continuously -> RST follows the done/IDLE cycle, with frames 14 cycles apart. The second frame uses the digits value sampled at its own start.
- Mid-frame reset: reset asserted during ADV of digit2 -> next cycle rw=0, busy=0, no done. A following start gives a full correct frame, and the display shows the new digits.
- Display-model check: after a frame with scan_spd=5'b00011, the display FSM is in SCAN and its digit pointer is at digit 3 (no extra shift).

Source files
------------

// File: rtl/zymason_seg_loader.sv
// Host-side initiator for the 7-segment digit store write protocol: replays a
// latched frame as reset / low-nibble / high-bits / advance cycles, then scans.
module zymason_seg_loader #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7*NUM_DIGITS-1:0] digits,
  input  logic [4:0]              scan_spd,
  output logic                    busy,
  output logic                    done,
  output logic                    tgt_reset,
  output logic                    rw,
  output logic                    sel,
  output logic [3:0]              pin_out
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_ADV  = 3'd4,
    S_EXIT = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7*NUM_DIGITS-1:0] frame_q, frame_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    tgt_reset_q, tgt_reset_d;
  logic                    rw_q, rw_d;
  logic                    sel_q, sel_d;
  logic [3:0]              pin_q, pin_d;
  logic [6:0]              digit_s;

  // Next-state sequencing of the write protocol and frame/index bookkeeping
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RST;
          idx_d   = {IDX_W{1'b0}};
          frame_d = digits;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RST:  state_d = S_LO;
      S_LO:   state_d = S_HI;
      S_HI: begin
        if (idx_q < LAST_IDX) begin
          state_d = S_ADV;
        end else begin
          state_d = S_EXIT;
        end
      end
      S_ADV: begin
        state_d = S_LO;
        idx_d   = idx_q + IDX_W'(1);
      end
      S_EXIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Digit addressed in the upcoming cycle, taken from the next-state frame
  always_comb begin
    digit_s = 7'(frame_d >> (7 * int'(idx_d)));
  end

  // Output values for the upcoming state; registered below so every pin is a flop
  always_comb begin
    busy_d      = 1'b1;
    done_d      = 1'b0;
    tgt_reset_d = 1'b0;
    rw_d        = 1'b1;
    sel_d       = 1'b0;
    pin_d       = digit_s[3:0];
    case (state_d)
      S_IDLE: begin
        busy_d         = 1'b0;
        done_d         = (state_q == S_EXIT);
        rw_d           = 1'b0;
        {pin_d, sel_d} = scan_spd;
      end
      S_RST: begin
        tgt_reset_d = 1'b1;
        rw_d        = 1'b0;
        pin_d       = 4'd0;
      end
      S_LO:  pin_d = digit_s[3:0];
      S_HI: begin
        sel_d = 1'b1;
        pin_d = {1'b0, digit_s[6:4]};
      end
      // Pointer-shift cycle: rewrite the current low nibble with its own value
      S_ADV: pin_d = digit_s[3:0];
      S_EXIT: begin
        rw_d           = 1'b0;
        {pin_d, sel_d} = scan_spd;
      end
      default: begin
        busy_d         = 1'b0;
        rw_d           = 1'b0;
        {pin_d, sel_d} = scan_spd;
      end
    endcase
  end

  // State, frame and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      frame_q     <= {(7*NUM_DIGITS){1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tgt_reset_q <= 1'b0;
      rw_q        <= 1'b0;
      sel_q       <= 1'b0;
      pin_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tgt_reset_q <= tgt_reset_d;
      rw_q        <= rw_d;
      sel_q       <= sel_d;
      pin_q       <= pin_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tgt_reset = tgt_reset_q;
  assign rw        = rw_q;
  assign sel       = sel_q;
  assign pin_out   = pin_q;

endmodule

// File: tb/tb_zymason_seg_loader.sv
// Directed bench for zymason_seg_loader with a small display-store model
// attached to its RW/sel/pin/reset outputs.
module tb_zymason_seg_loader;

  localparam int N = 4;
  localparam logic [27:0] DIG_A = {7'h7F, 7'h06, 7'h5B, 7'h3F};
  localparam logic [27:0] DIG_B = {7'h07, 7'h6D, 7'h66, 7'h4F};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [27:0] digits = 28'd0;
  logic [4:0]  scan_spd = 5'd0;
  logic        busy, done, tgt_reset, rw, sel;
  logic [3:0]  pin_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {tgt_reset, rw, sel, pin_out} per cycle, RST through EXIT (scan_spd = 5'b00011)
  logic [6:0] tab_a [13] = '{7'h40, 7'h2F, 7'h33, 7'h2F, 7'h2B, 7'h35, 7'h2B,
                             7'h26, 7'h30, 7'h26, 7'h2F, 7'h37, 7'h11};
  logic [6:0] tab_b [13] = '{7'h40, 7'h2F, 7'h34, 7'h2F, 7'h26, 7'h36, 7'h26,
                             7'h2D, 7'h36, 7'h2D, 7'h27, 7'h30, 7'h11};

  zymason_seg_loader #(.NUM_DIGITS(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .digits   (digits),
    .scan_spd (scan_spd),
    .busy     (busy),
    .done     (done),
    .tgt_reset(tgt_reset),
    .rw       (rw),
    .sel      (sel),
    .pin_out  (pin_out)
  );

  always #5 clock = ~clock;

  // Display digit-store model: RW=1 writes, sel picks nibble, LO after HI shifts pointer
  logic [6:0] disp_store [N];
  logic [1:0] disp_ptr;
  logic       disp_write;
  logic       disp_prev_hi;

  always @(posedge clock) begin
    if (reset || tgt_reset) begin
      for (int i = 0; i < N; i++) disp_store[i] <= 7'd0;
      disp_ptr     <= 2'd0;
      disp_write   <= 1'b0;
      disp_prev_hi <= 1'b0;
    end else if (rw) begin
      disp_write <= 1'b1;
      if (sel) begin
        disp_store[disp_ptr][6:4] <= pin_out[2:0];
        disp_prev_hi <= 1'b1;
      end else begin
        disp_store[disp_ptr][3:0] <= pin_out;
        if (disp_prev_hi) disp_ptr <= disp_ptr + 2'd1;
        disp_prev_hi <= 1'b0;
      end
    end else begin
      disp_write   <= 1'b0;
      disp_prev_hi <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Checks the 13 busy cycles starting at RST, then the done cycle; optionally pokes start/digits
  task automatic expect_frame(input bit use_b, input int poke_at, input bit hold);
    logic [6:0] e;
    for (int c = 0; c < 13; c++) begin
      e = use_b ? tab_b[c] : tab_a[c];
      check($sformatf("frame%s_c%0d", use_b ? "B" : "A", c),
            {23'd0, busy, done, tgt_reset, rw, sel, pin_out}, {23'd0, 2'b10, e});
      if (c == poke_at) begin
        digits = use_b ? DIG_A : DIG_B;
        start  = 1'b1;
      end else if (c == poke_at + 1 && !hold) begin
        start = 1'b0;
      end
      step();
    end
    check("done_cycle", {24'd0, busy, done, tgt_reset, rw, pin_out, sel},
          {24'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1});
  endtask

  task automatic check_display(input logic [27:0] exp_dig);
    logic [27:0] d;
    d = exp_dig;
    for (int i = 0; i < N; i++)
      check($sformatf("disp_digit%0d", i), {25'd0, disp_store[i]}, {25'd0, d[7*i +: 7]});
    check("disp_scan_mode", {31'd0, disp_write}, 32'd0);
    check("disp_ptr", {30'd0, disp_ptr}, 32'd3);
  endtask

  task automatic check_idle(input string tag);
    check(tag, {25'd0, busy, done, tgt_reset, rw, pin_out, sel},
          {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1});
  endtask

  initial begin
    // Reset and idle scan tracking
    scan_spd = 5'b10101;
    reset = 1'b1;
    step();
    step();
    check("reset_vals", {24'd0, busy, done, tgt_reset, rw, pin_out, sel}, 32'd0);
    reset = 1'b0;
    step();
    check("idle_scan", {24'd0, busy, done, tgt_reset, rw, pin_out, sel},
          {24'd0, 4'b0000, 4'b1010, 1'b1});
    scan_spd = 5'b00011;
    step();
    check_idle("idle_track");

    // Single frame
    digits = DIG_A;
    start  = 1'b1;
    step();
    start = 1'b0;
    expect_frame(1'b0, -1, 1'b0);
    check_display(DIG_A);
    step();
    check_idle("after_single");

    // start during HI of digit1 with other digits is ignored, not queued
    digits = DIG_A;
    start  = 1'b1;
    step();
    start = 1'b0;
    expect_frame(1'b0, 5, 1'b0);
    check_display(DIG_A);
    step();
    check_idle("ignored_no_queue");
    step();
    check_idle("ignored_still_idle");

    // Back-to-back: start held, second frame picks up digits present at its own start
    digits = DIG_A;
    start  = 1'b1;
    step();
    expect_frame(1'b0, 6, 1'b1);
    step();
    expect_frame(1'b1, -1, 1'b0);
    check_display(DIG_B);
    step();
    check_idle("after_b2b");

    // Reset during ADV of digit2
    digits = DIG_A;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 9; c++) step();
    check("at_adv2", {25'd0, busy, done, tgt_reset, rw, sel, pin_out}, {25'd0, 2'b10, 7'h26});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_vals", {24'd0, busy, done, tgt_reset, rw, pin_out, sel}, 32'd0);
    step();
    check_idle("midreset_no_done");
    digits = DIG_B;
    start  = 1'b1;
    step();
    start = 1'b0;
    expect_frame(1'b1, -1, 1'b0);
    check_display(DIG_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
